// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU and the ALU control decoder.
// Holds the operation codes, the FSM state encoding and the default widths.
package alu_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 32;
  localparam int DEFAULT_SHAMT_WIDTH = 5;

  // ALU operation codes, as produced by the ALU control decoder
  localparam logic [3:0] ALU_OP_ADD = 4'b0000;
  localparam logic [3:0] ALU_OP_SUB = 4'b0001;
  localparam logic [3:0] ALU_OP_AND = 4'b0010;
  localparam logic [3:0] ALU_OP_OR  = 4'b0011;
  localparam logic [3:0] ALU_OP_XOR = 4'b0100;
  localparam logic [3:0] ALU_OP_LUI = 4'b0101;
  localparam logic [3:0] ALU_OP_SRL = 4'b0110;
  localparam logic [3:0] ALU_OP_SLL = 4'b0111;

  // Sequencer states; SHIFT is only reachable in the iterative build
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } alu_state_t;

endpackage

// File: rtl/alu_multicycle_if.sv
// alu_multicycle_if: request/response bundle between the sequencer and the ALU.
//
// Handshake: the sequencer raises start_i with the operation and operands; the
// request is taken on a rising edge where busy_o is low (IDLE or DONE). Operands
// are sampled only on that edge. done_o pulses for one cycle when ALU_Result_o
// and Zero_o hold the new result; both stay stable until the next done_o.
interface alu_multicycle_if #(
  parameter int DATA_WIDTH = alu_pkg::DEFAULT_DATA_WIDTH
);

  logic                  start_i;
  logic [3:0]            ALU_Operation_i;
  logic [DATA_WIDTH-1:0] A_i;
  logic [DATA_WIDTH-1:0] B_i;
  logic                  busy_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] ALU_Result_o;
  logic                  Zero_o;

  // Sequencer side: issues requests, observes results
  modport master (
    output start_i,
    output ALU_Operation_i,
    output A_i,
    output B_i,
    input  busy_o,
    input  done_o,
    input  ALU_Result_o,
    input  Zero_o
  );

  // ALU side: consumes requests, produces results
  modport slave (
    input  start_i,
    input  ALU_Operation_i,
    input  A_i,
    input  B_i,
    output busy_o,
    output done_o,
    output ALU_Result_o,
    output Zero_o
  );

endinterface

// File: rtl/alu_logic_core.sv
// alu_logic_core: combinational evaluation of the single-step operations
// (ADD, SUB, AND, OR, XOR, LUI). Shift and reserved codes yield zero here;
// shifts are resolved by the sequencer in the top level.
module alu_logic_core
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result
);

  // Select the single-step result; add/sub wrap with no carry out
  always_comb begin
    result = '0;
    case (op)
      ALU_OP_ADD: result = a + b;
      ALU_OP_SUB: result = a - b;
      ALU_OP_AND: result = a & b;
      ALU_OP_OR:  result = a | b;
      ALU_OP_XOR: result = a ^ b;
      ALU_OP_LUI: result = {b[DATA_WIDTH-13:0], 12'h000};
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: multi-cycle execution ALU behind the ALU control decoder.
// Logic, arithmetic, LUI and reserved codes finish at the acceptance edge.
// SRL/SLL shift one bit per clock through a working register and counter.
//
// Build option: define ALU_SINGLE_CYCLE_SHIFT_EN to replace the iterative
// shifter with a barrel shifter; the SHIFT state and counter then disappear
// and busy_o is tied low.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int SHAMT_WIDTH = DEFAULT_SHAMT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  alu_multicycle_if.slave  bus,
  output alu_state_t       dbg_state
);

  alu_state_t            state_q;
  alu_state_t            state_d;
  logic [DATA_WIDTH-1:0] core_result;
  logic [DATA_WIDTH-1:0] result_q;
  logic [DATA_WIDTH-1:0] result_d;
  logic                  result_load;
  logic                  zero_q;
  logic                  is_shift;
  logic                  is_sll;
  logic [SHAMT_WIDTH-1:0] shamt;

`ifdef ALU_SINGLE_CYCLE_SHIFT_EN
  logic [DATA_WIDTH-1:0] barrel_result;
`else
  logic [DATA_WIDTH-1:0]  work_q;
  logic [DATA_WIDTH-1:0]  work_next;
  logic [SHAMT_WIDTH-1:0] cnt_q;
  logic                   dir_left_q;
  logic                   shift_load;
`endif

  alu_logic_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_core (
    .op     (bus.ALU_Operation_i),
    .a      (bus.A_i),
    .b      (bus.B_i),
    .result (core_result)
  );

  assign is_sll   = (bus.ALU_Operation_i == ALU_OP_SLL);
  assign is_shift = is_sll || (bus.ALU_Operation_i == ALU_OP_SRL);
  assign shamt    = bus.B_i[SHAMT_WIDTH-1:0];

`ifdef ALU_SINGLE_CYCLE_SHIFT_EN
  // Full shift in one step when the barrel shifter is built in
  always_comb begin
    barrel_result = '0;
    if (is_sll) barrel_result = bus.A_i << shamt;
    else        barrel_result = bus.A_i >> shamt;
  end
`else
  // One-bit step of the working register in the stored direction
  always_comb begin
    work_next = '0;
    if (dir_left_q) work_next = {work_q[DATA_WIDTH-2:0], 1'b0};
    else            work_next = {1'b0, work_q[DATA_WIDTH-1:1]};
  end
`endif

  // Next-state and result-load decisions; a start is taken in IDLE or DONE
  always_comb begin
    state_d     = state_q;
    result_d    = '0;
    result_load = 1'b0;
`ifndef ALU_SINGLE_CYCLE_SHIFT_EN
    shift_load  = 1'b0;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start_i) begin
          if (is_shift) begin
`ifdef ALU_SINGLE_CYCLE_SHIFT_EN
            result_load = 1'b1;
            result_d    = barrel_result;
            state_d     = DONE;
`else
            if (shamt == '0) begin
              // Zero-length shift: the result is A, no iteration needed
              result_load = 1'b1;
              result_d    = bus.A_i;
              state_d     = DONE;
            end else begin
              shift_load  = 1'b1;
              state_d     = SHIFT;
            end
`endif
          end else begin
            result_load = 1'b1;
            result_d    = core_result;
            state_d     = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
`ifndef ALU_SINGLE_CYCLE_SHIFT_EN
      SHIFT: begin
        // The last step's shifted value goes straight to the output register
        if (cnt_q == SHAMT_WIDTH'(1)) begin
          result_load = 1'b1;
          result_d    = work_next;
          state_d     = DONE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State register and registered result/zero flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      if (result_load) begin
        result_q <= result_d;
        zero_q   <= (result_d == '0);
      end
    end
  end

`ifndef ALU_SINGLE_CYCLE_SHIFT_EN
  // Working register, remaining-step counter and direction for iterative shifts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      work_q     <= '0;
      cnt_q      <= '0;
      dir_left_q <= 1'b0;
    end else if (shift_load) begin
      work_q     <= bus.A_i;
      cnt_q      <= shamt;
      dir_left_q <= is_sll;
    end else if (state_q == SHIFT) begin
      work_q     <= work_next;
      cnt_q      <= cnt_q - SHAMT_WIDTH'(1);
    end
  end
`endif

`ifdef ALU_SINGLE_CYCLE_SHIFT_EN
  assign bus.busy_o = 1'b0;
`else
  assign bus.busy_o = (state_q == SHIFT);
`endif
  assign bus.done_o       = (state_q == DONE);
  assign bus.ALU_Result_o = result_q;
  assign bus.Zero_o       = zero_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: self-checking bench for alu_multicycle (iterative build).
module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int W = 32;

  logic       clk = 1'b0;
  logic       reset;
  alu_state_t dbg_state;

  alu_multicycle_if #(.DATA_WIDTH(W)) bus ();

  alu_multicycle #(
    .DATA_WIDTH  (W),
    .SHAMT_WIDTH (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [W-1:0]  exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] actual, input logic [W-1:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Reference: what the operation means arithmetically
  function automatic logic [W-1:0] ref_result(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = b * 32'd4096;
      4'd6: r = a >> b[4:0];
      4'd7: r = a << b[4:0];
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input logic [W-1:0] b);
    if (op == 4'd6 || op == 4'd7) return int'(b[4:0]);
    return 0;
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int           busy_cnt;
    int           cycles;
    int           lat;
    logic [W-1:0] exp;
    exp_q.push_back(ref_result(op, a, b));
    lat = ref_latency(op, b);
    @(negedge clk);
    bus.start_i         = 1'b1;
    bus.ALU_Operation_i = op;
    bus.A_i             = a;
    bus.B_i             = b;
    @(negedge clk);
    // Operands change after acceptance; the ALU must ignore them
    bus.start_i         = 1'b0;
    bus.A_i             = $urandom();
    bus.B_i             = $urandom();
    bus.ALU_Operation_i = 4'($urandom_range(0, 15));
    busy_cnt = 0;
    cycles   = 0;
    while (bus.done_o !== 1'b1 && cycles < 40) begin
      if (bus.busy_o === 1'b1) busy_cnt++;
      @(negedge clk);
      cycles++;
    end
    exp = exp_q.pop_front();
    check({tag, "/done"},   W'(bus.done_o), W'(1));
    check({tag, "/busy"},   W'(busy_cnt), W'(lat));
    check({tag, "/result"}, bus.ALU_Result_o, exp);
    check({tag, "/zero"},   W'(bus.Zero_o), W'(exp == '0));
    @(negedge clk);
    check({tag, "/pulse"},  W'(bus.done_o), W'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cycles;
    int done_seen;

    reset               = 1'b0;
    bus.start_i         = 1'b0;
    bus.ALU_Operation_i = 4'd0;
    bus.A_i             = '0;
    bus.B_i             = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst/result", bus.ALU_Result_o, '0);
    check("rst/zero",   W'(bus.Zero_o), W'(1));
    check("rst/busy",   W'(bus.busy_o), W'(0));
    check("rst/done",   W'(bus.done_o), W'(0));
    check("rst/state",  W'(dbg_state), W'(IDLE));

    // Directed cases
    run_op("add",      4'd0, 32'd5,          32'd7);
    run_op("sub_eq",   4'd1, 32'd3,          32'd3);
    run_op("sub_wrap", 4'd1, 32'd0,          32'd1);
    run_op("sll4",     4'd7, 32'd1,          32'd4);
    run_op("srl31",    4'd6, 32'h8000_0000,  32'd31);
    run_op("sll0",     4'd7, 32'hDEAD_BEEF,  32'h20);
    run_op("lui",      4'd5, 32'd0,          32'h12345);
    run_op("rsvd",     4'd10, 32'h1234_5678, 32'h9ABC_DEF0);
    run_op("and",      4'd2, 32'hFF00_FF00,  32'h0F0F_0F0F);
    run_op("or",       4'd3, 32'hFF00_0000,  32'h0000_00FF);

    // Start held high through a shift with changing operands, then back-to-back
    @(negedge clk);
    bus.start_i         = 1'b1;
    bus.ALU_Operation_i = 4'd7;
    bus.A_i             = 32'h3;
    bus.B_i             = 32'd8;
    @(negedge clk);
    cycles = 0;
    while (bus.done_o !== 1'b1 && cycles < 40) begin
      bus.A_i             = $urandom();
      bus.B_i             = $urandom();
      bus.ALU_Operation_i = 4'($urandom_range(0, 15));
      @(negedge clk);
      cycles++;
    end
    check("hold/cycles", W'(cycles), W'(8));
    check("hold/result", bus.ALU_Result_o, ref_result(4'd7, 32'h3, 32'd8));
    bus.ALU_Operation_i = 4'd4;
    bus.A_i             = 32'hF0;
    bus.B_i             = 32'hFF;
    @(negedge clk);
    bus.start_i = 1'b0;
    check("b2b/done",   W'(bus.done_o), W'(1));
    check("b2b/result", bus.ALU_Result_o, 32'h0F);
    check("b2b/zero",   W'(bus.Zero_o), W'(0));
    @(negedge clk);
    check("b2b/pulse",  W'(bus.done_o), W'(0));

    // Reset in the middle of a 10-step shift
    @(negedge clk);
    bus.start_i         = 1'b1;
    bus.ALU_Operation_i = 4'd7;
    bus.A_i             = 32'h0000_0001;
    bus.B_i             = 32'd10;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst/result", bus.ALU_Result_o, '0);
    check("midrst/zero",   W'(bus.Zero_o), W'(1));
    check("midrst/busy",   W'(bus.busy_o), W'(0));
    check("midrst/done",   W'(bus.done_o), W'(0));
    check("midrst/state",  W'(dbg_state), W'(IDLE));
    done_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) done_seen++;
    end
    reset = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) done_seen++;
    end
    check("midrst/no_done", W'(done_seen), W'(0));
    run_op("post_rst_add", 4'd0, 32'h0000_1000, 32'h0000_0234);

    // Randomized operations against the reference model
    for (int i = 0; i < 30; i++) begin
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom();
      b  = $urandom();
      if ($urandom_range(0, 3) == 0) b = a;
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Multi-cycle execution ALU sitting directly downstream of the ALU control decoder: consumes the 4-bit ALU operation code, the two operands from the register file / immediate mux, and a start strobe, and returns a registered result plus zero flag with a done pulse. Logic, arithmetic and LUI complete at the acceptance edge. Shifts run iteratively, one bit per clock, to keep the datapath small. Intended for the multi-cycle evolution of the core, where the sequencer waits on `done_o`.

## Interface
- `DATA_WIDTH`, 32, operand/result width
- `SHAMT_WIDTH`, 5, shift-amount width (log2 DATA_WIDTH)

- `clk` in 1: rising-edge clock
- `reset` in 1: asynchronous, active-low reset
- `start_i` in 1: request; accepted only when not busy
- `ALU_Operation_i` in 4: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 LUI, 0110 SRL, 0111 SLL, others reserved
- `A_i` in DATA_WIDTH: operand A (rs1)
- `B_i` in DATA_WIDTH: operand B (rs2 or immediate); shift amount = `B_i[SHAMT_WIDTH-1:0]`
- `busy_o` out 1: shift in progress; start ignored
- `done_o` out 1: one-cycle pulse, result valid
- `ALU_Result_o` out DATA_WIDTH: registered result, held until next done
- `Zero_o` out 1: registered, 1 when the result is all zeros; updates with `ALU_Result_o`

## Operation
- States: IDLE, SHIFT, DONE. Acceptance is `start_i`=1 while in IDLE or DONE (back-to-back allowed). In SHIFT, `start_i` is ignored and not queued.
- Non-shift ops and reserved codes: the result is written at the acceptance edge, and the FSM goes to DONE.
  - ADD: A+B. SUB: A−B. Both are mod 2^DATA_WIDTH with no carry or overflow output.
  - AND, OR, XOR: bitwise.
  - LUI: `{B[19:0], 12'h000}`.
  - Reserved codes: result 0.
- Shift with amount n=0: the result is A, written at the acceptance edge, and the FSM goes to DONE.
- Shift with n>0: at the acceptance edge, load the working register with A, set the counter to n, store the direction, and go to SHIFT.
  - Each SHIFT edge shifts one bit (SRL logical, zero fill; SLL zero fill) and decrements the counter.
  - At the edge where the counter equals 1, write the final value to `ALU_Result_o` and go to DONE.
- DONE lasts exactly one cycle. It then returns to IDLE, or directly accepts a new start.
- Operands are sampled only at acceptance. Changes on `A_i`, `B_i` or `ALU_Operation_i` during SHIFT have no effect.
- `busy_o` = (state==SHIFT). `done_o` = (state==DONE).
- Reset (any time, including mid-shift): state IDLE, `ALU_Result_o`=0, `Zero_o`=1, `busy_o`=0, `done_o`=0, counter 0. The in-flight operation is discarded.

## Timing
- Acceptance at edge k. The result and `done_o` are visible in the cycle after edge k+n, where n = shift amount for SRL/SLL and 0 otherwise.
- `busy_o` is high for exactly n cycles, following edge k.
- Maximum latency is 31 edges (SRL/SLL by 31).
- `done_o` is never high for two consecutive cycles unless a new acceptance occurs in DONE.

## Configuration
- `ALU_SINGLE_CYCLE_SHIFT_EN` defined:
  - SRL/SLL use a barrel shifter and complete at the acceptance edge like every other op.
  - SHIFT state and counter are not compiled in.
  - `busy_o` is tied 0.
- Undefined (default): iterative shifter exactly as in Operation.

## Structure
- Package `alu_pkg`:
  - ALU op localparams (values above) shared with the ALU control decoder.
  - FSM state encoding (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10).
  - `DATA_WIDTH`/`SHAMT_WIDTH` defaults.
- Sub-module `alu_logic_core`: purely combinational ADD/SUB/AND/OR/XOR/LUI/reserved evaluation. The top holds the FSM, shift register, counter and output registers.

## Test plan
- Reset 0 → 1, idle → `ALU_Result_o`=0, `Zero_o`=1, `busy_o`=0, `done_o`=0.
- ADD A=5, B=7, start at edge k → `done_o`=1 after edge k, result=12, `Zero_o`=0. SUB A=3, B=3 → result 0, `Zero_o`=1. SUB A=0, B=1 → 0xFFFFFFFF.
- SLL A=1, B=4 → `busy_o` high 4 cycles, result 0x10 after edge k+4. SRL A=0x80000000, B=31 → result 0x1 after edge k+31. SLL with B=0x20 (shamt 0) → result A after edge k.
- Start SLL by 8, hold `start_i` high and change operands during SHIFT → only one `done_o`, result from the original operands. Then a start in the DONE cycle (XOR A=0xF0, B=0xFF) → result 0x0F the next cycle.
- LUI B=0x12345 → 0x12345000. Reserved code 1010 → result 0, `done_o` after edge k.
- Assert `reset` at shift step 3 of 10 → all outputs at reset values immediately, no `done_o`. A new ADD after release works normally.
